// File: rtl/launcher_pkg.sv
// Shared types and helpers for the program launcher: FSM state encoding,
// default widths and the address-range helper used by elaboration checks.
package launcher_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  localparam int DEF_CW = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    REQ   = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    FLUSH = 3'd5
  } state_t;

  // One past the last address touched by a block of n bytes starting at base.
  function automatic longint addr_end(input longint base, input longint n);
    return base + n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a terminal-value match.
// Used to measure req-to-done latency and to detect the run timeout.
module sat_counter #(
  parameter int           W    = 16,
  parameter logic [W-1:0] TERM = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         hit
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  // Clear dominates; otherwise count up and stick at all-ones.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en && (count_reg != '1)) begin
      count_next = count_reg + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign hit   = (count_reg == TERM);

endmodule

// File: rtl/prog_launcher.sv
// Host-side run initiator: loads an operand block into data memory, pulses
// dut_req, waits for dut_done (with settle window and timeout), then streams
// the result block out through a single-entry output register.
module prog_launcher
  import launcher_pkg::*;
#(
  parameter int          AW       = DEF_AW,
  parameter int          DW       = DEF_DW,
  parameter int          LD_BASE  = 0,
  parameter int          N_LD     = 64,
  parameter int          RES_BASE = 64,
  parameter int          N_RES    = 32,
  parameter int          CW       = DEF_CW,
  parameter int unsigned TIMEOUT  = 32'hFFF0,
  parameter int          SETTLE   = 2
) (
  input  logic          clk,
  input  logic          reset,        // asynchronous, active-low
  input  logic          start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          mem_sel,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data,
  output logic          dut_req,
  input  logic          dut_done,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  input  logic          res_ready,
  output logic          busy,
  output logic          run_ok,
  output logic          timeout_err,
  output logic [CW-1:0] run_cycles
);

  localparam int            SW        = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [AW-1:0] LD_FIRST  = AW'(LD_BASE);
  localparam logic [AW-1:0] LD_LAST   = AW'(LD_BASE + N_LD - 1);
  localparam logic [AW-1:0] RES_FIRST = AW'(RES_BASE);
  localparam logic [AW-1:0] RES_LAST  = AW'(RES_BASE + N_RES - 1);

  // Blocks must fit in memory so the inline address counter never wraps.
  if (addr_end(LD_BASE, N_LD) > (longint'(1) << AW)) begin : g_chk_ld
    $fatal(1, "prog_launcher: load block exceeds the address space");
  end
  if (addr_end(RES_BASE, N_RES) > (longint'(1) << AW)) begin : g_chk_res
    $fatal(1, "prog_launcher: result block exceeds the address space");
  end
  if (longint'(TIMEOUT) >= (longint'(1) << CW)) begin : g_chk_to
    $fatal(1, "prog_launcher: TIMEOUT does not fit in CW bits");
  end

  state_t        state_reg, state_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [SW-1:0] settle_reg, settle_next;
  logic          res_valid_reg, res_valid_next;
  logic [DW-1:0] res_data_reg, res_data_next;
  logic          to_err_reg, to_err_next;

  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_hit;
  logic          done_ok;

  // Run-length counter; hit marks the timeout threshold.
  sat_counter #(
    .W    (CW),
    .TERM (CW'(TIMEOUT))
  ) u_run_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (run_cycles),
    .hit   (cnt_hit)
  );

  // Next-state and output decode; every output defaults to idle values.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    settle_next    = settle_reg;
    res_valid_next = res_valid_reg;
    res_data_next  = res_data_reg;
    to_err_next    = to_err_reg;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;
    ld_ready       = 1'b0;
    mem_sel        = 1'b0;
    mem_wr_en      = 1'b0;
    mem_wr_data    = '0;
    dut_req        = 1'b0;
    run_ok         = 1'b0;
    // A done level is only trusted once the settle window has expired.
    done_ok        = dut_done && (settle_reg == '0);

    case (state_reg)
      IDLE: begin
        if (start) begin
          to_err_next = 1'b0;
          cnt_clr     = 1'b1;
          addr_next   = LD_FIRST;
          state_next  = (N_LD == 0) ? REQ : LOAD;
        end
      end
      LOAD: begin
        mem_sel  = 1'b1;
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_wr_en   = 1'b1;
          mem_wr_data = ld_data;
          addr_next   = addr_reg + AW'(1);
          if (addr_reg == LD_LAST) begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        // Counter was cleared at start, so this increment makes it 1.
        dut_req     = 1'b1;
        cnt_en      = 1'b1;
        settle_next = SW'(SETTLE);
        state_next  = RUN;
      end
      RUN: begin
        if (settle_reg != '0) begin
          settle_next = settle_reg - SW'(1);
        end
        if (done_ok) begin
          cnt_en     = 1'b1;
          addr_next  = RES_FIRST;
          state_next = (N_RES == 0) ? FLUSH : DRAIN;
        end else if (cnt_hit) begin
          // Counter is left at the threshold value on abort.
          to_err_next = 1'b1;
          state_next  = IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DRAIN: begin
        mem_sel = 1'b1;
        if (!res_valid_reg || res_ready) begin
          res_valid_next = 1'b1;
          res_data_next  = mem_rd_data;
          addr_next      = addr_reg + AW'(1);
          if (addr_reg == RES_LAST) begin
            state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (!res_valid_reg || res_ready) begin
          res_valid_next = 1'b0;
          run_ok         = 1'b1;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, address, settle and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      settle_reg    <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      to_err_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      settle_reg    <= settle_next;
      res_valid_reg <= res_valid_next;
      res_data_reg  <= res_data_next;
      to_err_reg    <= to_err_next;
    end
  end

  assign mem_addr    = addr_reg;
  assign res_valid   = res_valid_reg;
  assign res_data    = res_data_reg;
  assign timeout_err = to_err_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_prog_launcher.sv
// Bench for prog_launcher: a memory model, a processor model driving
// dut_done, and a scoreboard fed by the stimulus and drained by a monitor.
module tb_prog_launcher;

  localparam int AW = 8, DW = 8, CW = 16;
  localparam int LD_BASE = 0, N_LD = 4, RES_BASE = 64, N_RES = 4;
  localparam int TIMEOUT = 50, SETTLE = 2, TIMEOUT1 = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start, ld_valid, ld_ready, mem_sel, mem_wr_en, dut_req, dut_done;
  logic          res_valid, res_ready, busy, run_ok, timeout_err;
  logic [DW-1:0] ld_data, mem_wr_data, mem_rd_data, res_data;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] run_cycles;

  logic          start1, done1, ld_ready1, mem_sel1, mem_wr_en1, dut_req1;
  logic          res_valid1, busy1, run_ok1, timeout_err1;
  logic [DW-1:0] mem_wr_data1, res_data1;
  logic [AW-1:0] mem_addr1;
  logic [CW-1:0] run_cycles1;

  prog_launcher #(
    .AW(AW), .DW(DW), .LD_BASE(LD_BASE), .N_LD(N_LD), .RES_BASE(RES_BASE),
    .N_RES(N_RES), .CW(CW), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .mem_sel(mem_sel), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .dut_req(dut_req),
    .dut_done(dut_done), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .busy(busy), .run_ok(run_ok), .timeout_err(timeout_err),
    .run_cycles(run_cycles)
  );

  // Second instance with empty load and result blocks.
  prog_launcher #(
    .AW(AW), .DW(DW), .LD_BASE(0), .N_LD(0), .RES_BASE(RES_BASE),
    .N_RES(0), .CW(CW), .TIMEOUT(TIMEOUT1), .SETTLE(SETTLE)
  ) dut_empty (
    .clk(clk), .reset(reset), .start(start1), .ld_valid(1'b0), .ld_data(8'h00),
    .ld_ready(ld_ready1), .mem_sel(mem_sel1), .mem_wr_en(mem_wr_en1), .mem_addr(mem_addr1),
    .mem_wr_data(mem_wr_data1), .mem_rd_data(8'h00), .dut_req(dut_req1),
    .dut_done(done1), .res_valid(res_valid1), .res_data(res_data1),
    .res_ready(1'b1), .busy(busy1), .run_ok(run_ok1), .timeout_err(timeout_err1),
    .run_cycles(run_cycles1)
  );

  // Data memory: operand area written by the launcher, result window
  // written by the processor model.
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] res_mem [0:N_RES-1];
  assign mem_rd_data = (int'(mem_addr) >= RES_BASE && int'(mem_addr) < RES_BASE + N_RES)
                       ? res_mem[int'(mem_addr) - RES_BASE] : mem[mem_addr];
  always @(posedge clk) if (mem_sel && mem_wr_en) mem[mem_addr] <= mem_wr_data;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { bit ok; int cyc; } evt_t;
  wr_t           exp_wr[$];
  logic [DW-1:0] exp_res[$];
  evt_t          exp_evt[$];

  int errors = 0, checks = 0;
  int rx_cnt = 0, hold_at = -1, hold_left = 0;
  bit rdy_rand = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string p);
    chk({p, "_busy"}, busy, 0);        chk({p, "_res_valid"}, res_valid, 0);
    chk({p, "_res_data"}, res_data, 0); chk({p, "_mem_sel"}, mem_sel, 0);
    chk({p, "_mem_addr"}, mem_addr, 0); chk({p, "_mem_wr_en"}, mem_wr_en, 0);
    chk({p, "_run_cycles"}, run_cycles, 0); chk({p, "_timeout"}, timeout_err, 0);
    chk({p, "_run_ok"}, run_ok, 0);    chk({p, "_dut_req"}, dut_req, 0);
    chk({p, "_ld_ready"}, ld_ready, 0);
  endtask

  // Consumer: random or steady ready, with an optional 5-cycle stall.
  initial begin
    res_ready = 1'b0;
    forever begin
      tick();
      if (hold_at >= 0 && rx_cnt == hold_at) begin
        hold_at   = -1;
        hold_left = 5;
      end
      if (hold_left > 0) begin
        res_ready = 1'b0;
        hold_left--;
      end else begin
        res_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every write, result handshake and run end.
  initial begin
    bit            stall_prev = 0, req_prev = 0, to_prev = 0, sel_prev = 0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] prev_addr = '0;
    wr_t           w;
    evt_t          e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_prev = 0; req_prev = 0; to_prev = 0; sel_prev = 0;
      end else begin
        if (mem_wr_en) begin
          if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            w = exp_wr.pop_front();
            chk("wr_addr", mem_addr, w.a);
            chk("wr_data", mem_wr_data, w.d);
            chk("wr_sel", mem_sel, 1);
          end
        end
        if (stall_prev) begin
          chk("hold_valid", res_valid, 1);
          chk("hold_data", res_data, prev_data);
          if (sel_prev && mem_sel) chk("hold_addr", mem_addr, prev_addr);
        end
        if (res_valid && res_ready) begin
          rx_cnt++;
          if (exp_res.size() == 0) chk("unexpected_result", 1, 0);
          else chk("res_data", res_data, exp_res.pop_front());
        end
        if (dut_req) chk("req_single", req_prev, 0);
        if (run_ok || (timeout_err && !to_prev)) begin
          if (exp_evt.size() == 0) chk("unexpected_end", 1, 0);
          else begin
            e = exp_evt.pop_front();
            chk("end_run_ok", run_ok, e.ok);
            chk("end_timeout", timeout_err, !e.ok);
            chk("end_run_cycles", run_cycles, e.cyc);
            chk("end_busy", busy, e.ok);
          end
        end
        stall_prev = res_valid && !res_ready;
        prev_data  = res_data;
        prev_addr  = mem_addr;
        sel_prev   = mem_sel;
        req_prev   = dut_req;
        to_prev    = timeout_err;
      end
    end
  end

  // One run: lat = cycles after req at which done rises, stale = done already
  // high from the last run, hold = result count at which ready stalls,
  // rr = random ready, dir = fixed A0.. results, bs = start pulse while busy,
  // rst_at = result count at which reset is asserted.
  task automatic run(input int lat, input bit stale, input int hold, input bit rr,
                     input bit dir, input bit bs, input int rst_at);
    logic [DW-1:0] ops [N_LD];
    int k, i, g;
    for (int j = 0; j < N_LD; j++) begin
      ops[j] = DW'($urandom);
      exp_wr.push_back('{a: AW'(LD_BASE + j), d: ops[j]});
    end
    rx_cnt = 0; hold_at = hold; rdy_rand = rr;
    start = 1'b1; tick(); start = 1'b0;
    chk("start_clears_timeout", timeout_err, 0);
    chk("start_clears_cycles", run_cycles, 0);
    chk("start_busy", busy, 1);
    i = 0; g = 0;
    while (i < N_LD && g < 200) begin
      if ($urandom_range(0, 2) == 0) ld_valid = 1'b0;
      else begin
        ld_valid = 1'b1; ld_data = ops[i];
        if (ld_ready) i++;
      end
      tick(); g++;
    end
    ld_valid = 1'b0;
    chk("load_count", i, N_LD);
    g = 0;
    while (!dut_req && g < 20) begin tick(); g++; end
    chk("req_seen", dut_req, 1);
    // Processor model: results appear in the result window once req is seen.
    for (int j = 0; j < N_RES; j++)
      res_mem[j] = dir ? DW'(8'hA0 + j) : (ops[j % N_LD] ^ DW'(8'h5A + 3 * j));
    if (!stale) dut_done = 1'b0;
    k = stale ? SETTLE + 1 : ((lat > SETTLE + 1) ? lat : SETTLE + 1);
    if (k <= TIMEOUT) begin
      for (int j = 0; j < N_RES; j++) exp_res.push_back(res_mem[j]);
      exp_evt.push_back('{ok: 1'b1, cyc: k + 1});
    end else begin
      exp_evt.push_back('{ok: 1'b0, cyc: TIMEOUT});
    end
    if (!stale)
      for (int c = 1; c <= lat && c <= TIMEOUT; c++) begin
        tick();
        if (c == lat) dut_done = 1'b1;
        if (bs && c == 3) start = 1'b1;
        if (c == 4) start = 1'b0;
      end
    start = 1'b0;
    g = 0;
    while (busy && g < 400) begin
      if (rst_at >= 0 && rx_cnt == rst_at) begin
        rst_at = -1;
        #2 reset = 1'b0;
        #1 check_zero("async_rst");
        exp_res.delete(); exp_evt.delete(); exp_wr.delete();
        tick();
        reset = 1'b1;
      end
      tick(); g++;
    end
    chk("run_end_idle", busy, 0);
    hold_at = -1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = '0; dut_done = 1'b0;
    start1 = 1'b0; done1 = 1'b0;
    for (int j = 0; j < (1 << AW); j++) mem[j] = '0;
    for (int j = 0; j < N_RES; j++) res_mem[j] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    chk("reset_empty_busy", busy1, 0);
    reset = 1'b1;
    tick();

    run(37, 0, 2, 0, 1, 1, -1);                // A0..A3, run_cycles 38, stall mid-drain
    run(0, 1, -1, 0, 0, 0, -1);                // stale done: accepted after settle
    run(60, 0, -1, 0, 0, 0, -1);               // done never arrives: timeout
    run(TIMEOUT, 0, -1, 1, 0, 0, -1);          // done on the threshold cycle wins
    run(TIMEOUT + 1, 0, -1, 1, 0, 0, -1);      // one cycle late: timeout
    repeat (6) run($urandom_range(1, TIMEOUT + 5), 0, $urandom_range(0, N_RES), 1, 0,
                   1'($urandom_range(0, 1)), -1);
    run(12, 0, -1, 1, 0, 0, 1);                // reset during drain
    run(9, 0, 1, 1, 0, 0, -1);                 // clean run afterwards

    // Empty blocks: IDLE -> REQ -> RUN -> FLUSH.
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("empty_req", dut_req1, 1);
    chk("empty_ld_ready", ld_ready1, 0);
    chk("empty_sel_req", mem_sel1, 0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("empty_req_low", dut_req1, 0);
      chk("empty_sel_run", mem_sel1, 0);
      chk("empty_no_run_ok", run_ok1, 0);
      if (c == 5) done1 = 1'b1;
    end
    tick();
    chk("empty_run_ok", run_ok1, 1);
    chk("empty_run_cycles", run_cycles1, 6);
    chk("empty_busy_flush", busy1, 1);
    chk("empty_res_valid", res_valid1, 0);
    chk("empty_addr", mem_addr1, RES_BASE);
    tick();
    done1 = 1'b0;
    chk("empty_run_ok_end", run_ok1, 0);
    chk("empty_idle", busy1, 0);
    chk("empty_timeout", timeout_err1, 0);
    chk("empty_wr", {mem_wr_en1, mem_wr_data1, res_data1}, 0);

    chk("left_writes", exp_wr.size(), 0);
    chk("left_results", exp_res.size(), 0);
    chk("left_ends", exp_evt.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_launcher.md
Name: prog_launcher

Overview:
- Host-side initiator for the processor's req/done run interface. Loads an operand block into data memory through a borrowed memory write port. Then pulses req and waits for done, with a timeout. Finally streams a result block back out of data memory.
- Sits beside the processor top level.
- Owns the data-memory port only while mem_sel is high; the top level steers its memory mux with mem_sel.

Parameters:
- AW, 8, data-memory address width.
- DW, 8, data width.
- LD_BASE, 0, first memory address written during load.
- N_LD, 64, operand bytes loaded per run (0 = skip load).
- RES_BASE, 64, first memory address read during drain.
- N_RES, 32, result bytes drained per run (0 = skip drain).
- CW, 16, cycle-counter width.
- TIMEOUT, 16'hFFF0, run cycles allowed before abort. Must satisfy TIMEOUT < 2^CW.
- SETTLE, 2, cycles after req during which dut_done is ignored.
- Elaboration check: LD_BASE+N_LD ≤ 2^AW and RES_BASE+N_RES ≤ 2^AW, else $fatal.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: begin a run; sampled only in IDLE.
- ld_valid, input, 1: operand byte available.
- ld_data, input, DW: operand byte.
- ld_ready, output, 1: launcher accepts ld_data this cycle.
- mem_sel, output, 1: launcher owns the memory port.
- mem_wr_en, output, 1: memory write strobe.
- mem_addr, output, AW: memory address.
- mem_wr_data, output, DW: memory write data.
- mem_rd_data, input, DW: combinational read data for mem_addr.
- dut_req, output, 1: processor start request.
- dut_done, input, 1: processor finished (level).
- res_valid, output, 1: result byte valid.
- res_data, output, DW: result byte.
- res_ready, input, 1: consumer accepts result.
- busy, output, 1: high in every state except IDLE.
- run_ok, output, 1: one-cycle pulse at successful completion.
- timeout_err, output, 1: sticky timeout flag; cleared on the next accepted start.
- run_cycles, output, CW: cycles from req to done, saturating.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs are 0, including res_data, run_cycles and timeout_err. Internal counters are 0.
- States: IDLE, LOAD, REQ, RUN, DRAIN, FLUSH.
- IDLE:
  - start=1 → clear timeout_err and run_cycles, set addr=LD_BASE.
  - Next state is LOAD, or REQ if N_LD=0.
  - start in any other state is ignored. dut_done is ignored in IDLE.
- LOAD:
  - mem_sel=1 and ld_ready=1.
  - On each cycle with ld_valid: mem_wr_en=1, mem_addr=addr, mem_wr_data=ld_data (combinational pass-through), then addr++.
  - After the N_LD-th write → REQ.
  - ld_valid low stalls the load with no write and no timeout.
- REQ:
  - dut_req=1 for exactly one cycle; mem_sel=0.
  - run_cycles starts at 1; settle counter loaded with SETTLE.
  - → RUN.
- RUN:
  - mem_sel=0. run_cycles increments each cycle, saturating at all-ones.
  - dut_done is ignored while the settle counter is nonzero, so a stale done level from the previous run is discarded.
  - dut_done=1 after settle → addr=RES_BASE, then DRAIN, or FLUSH if N_RES=0.
  - If run_cycles reaches TIMEOUT first → timeout_err=1 and return to IDLE. No drain and no run_ok on this path.
  - Done and timeout in the same cycle: done wins.
- DRAIN:
  - mem_sel=1, mem_wr_en=0, mem_addr=addr.
  - A single-entry output register holds res_valid/res_data.
  - When the register is empty, or is being consumed (res_valid&&res_ready): load mem_rd_data, set res_valid=1, addr++.
  - After the N_RES-th capture → FLUSH.
  - Throughput is one byte per cycle with res_ready held high.
  - Back-pressure holds res_data stable.
- FLUSH:
  - mem_sel=0. Waits until the output register empties (res_valid&&res_ready or already empty).
  - Then run_ok=1 for one cycle → IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Any partial load or drain is abandoned.
- Address arithmetic is AW bits. The parameter checks guarantee no wrap-around.

Decomposition:
- Package launcher_pkg holds:
  - the state_t enum (IDLE, LOAD, REQ, RUN, DRAIN, FLUSH);
  - the default-width localparams;
  - function addr_end(base, n) used in the elaboration checks.
- One sub-module, sat_counter (width CW, clear, enable, saturating, terminal-match output). It is instantiated for run_cycles/timeout.
- Address and settle counters stay inline.

Test Plan:
- N_LD=4, ld_data 8'h11,22,33,44 with gaps in ld_valid → four writes to addrs 0..3 only on valid cycles, then a single-cycle dut_req.
- Model the DUT as done=1 for 37 cycles after req, with memory 64..67 = A0..A3 and N_RES=4 → res_data A0,A1,A2,A3; run_cycles=38; one run_ok pulse.
- Hold res_ready low 5 cycles mid-drain → res_data holds, no byte is lost or duplicated, addr does not advance.
- dut_done stuck high from the previous run, TIMEOUT=20 → done is ignored for SETTLE cycles, then accepted. With done held low instead: timeout_err=1 at cycle 20, no run_ok, state IDLE.
- Pulse start while busy → no effect. Assert reset during DRAIN → all outputs 0 asynchronously; a new start runs cleanly.
- N_LD=0, N_RES=0 → IDLE→REQ→RUN→FLUSH, with run_ok one cycle after done is accepted.
